// File: rtl/mux16_to_1_mux4.sv
// Combinational 4:1 lane selector; the building block of the 16:1 selection tree.
module mux4_to_1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic [WIDTH-1:0] i_d2,
  input  logic [WIDTH-1:0] i_d3,
  input  logic [1:0]       i_sel,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule

// File: rtl/mux16_to_1.sv
// Registered 16:1 multiplexer built as a two-level tree of 4:1 muxes.
// Output and valid update one cycle after a qualified select; out holds when idle.
module mux16_to_1 #(
  parameter  int unsigned WIDTH     = 1,
  localparam int unsigned NUM_LANES = 16,
  localparam int unsigned SEL_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_LANES*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       in_valid,
  output logic [WIDTH-1:0]           out,
  output logic                       out_valid
);

  logic [WIDTH-1:0] w_grp [4];
  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;

  // First level: group g covers lanes 4g..4g+3, indexed by sel[1:0].
  for (genvar g = 0; g < 4; g++) begin : g_l1
    mux4_to_1 #(.WIDTH(WIDTH)) u_l1 (
      .i_d0  (in[(4*g+0)*WIDTH +: WIDTH]),
      .i_d1  (in[(4*g+1)*WIDTH +: WIDTH]),
      .i_d2  (in[(4*g+2)*WIDTH +: WIDTH]),
      .i_d3  (in[(4*g+3)*WIDTH +: WIDTH]),
      .i_sel (sel[1:0]),
      .o_y   (w_grp[g])
    );
  end

  mux4_to_1 #(.WIDTH(WIDTH)) u_l2 (
    .i_d0  (w_grp[0]),
    .i_d1  (w_grp[1]),
    .i_d2  (w_grp[2]),
    .i_d3  (w_grp[3]),
    .i_sel (sel[3:2]),
    .o_y   (w_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) r_out <= w_sel;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux16_to_1.sv
// Self-checking bench for mux16_to_1 at WIDTH=1 and WIDTH=8 against an array-indexed reference model.
module tb_mux16_to_1;

  logic         clk = 1'b0;
  logic         rst;
  logic         lane1 [16];
  logic [7:0]   lane8 [16];
  logic [15:0]  in1;
  logic [127:0] in8;
  logic [3:0]   sel1, sel8;
  logic         v1, v8;
  logic         out1;
  logic [7:0]   out8;
  logic         ov1, ov8;

  logic         m_out1, m_v1, m_v8;
  logic [7:0]   m_out8;
  logic [15:0]  pat;
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  always_comb begin
    in1 = '0;
    in8 = '0;
    for (int k = 0; k < 16; k++) begin
      in1[k]       = lane1[k];
      in8[k*8 +: 8] = lane8[k];
    end
  end

  mux16_to_1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in(in1), .sel(sel1), .in_valid(v1),
    .out(out1), .out_valid(ov1)
  );

  mux16_to_1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in(in8), .sel(sel8), .in_valid(v8),
    .out(out8), .out_valid(ov8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: advance the reference model with the inputs present at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_out1 = 1'b0; m_v1 = 1'b0;
      m_out8 = 8'h00; m_v8 = 1'b0;
    end else begin
      m_v1 = v1;
      if (v1) m_out1 = lane1[sel1];
      m_v8 = v8;
      if (v8) m_out8 = lane8[sel8];
    end
    #1;
    check_eq("out1", {31'b0, out1}, {31'b0, m_out1});
    check_eq("vld1", {31'b0, ov1},  {31'b0, m_v1});
    check_eq("out8", {24'b0, out8}, {24'b0, m_out8});
    check_eq("vld8", {31'b0, ov8},  {31'b0, m_v8});
  endtask

  task automatic set_lanes1(input logic [15:0] val);
    for (int k = 0; k < 16; k++) lane1[k] = val[k];
  endtask

  initial begin
    m_out1 = 1'b0; m_v1 = 1'b0; m_out8 = 8'h00; m_v8 = 1'b0;

    // Reset held two cycles with a valid all-ones request pending.
    rst = 1'b1; v1 = 1'b1; v8 = 1'b1; sel1 = 4'd0; sel8 = 4'd0;
    set_lanes1(16'hFFFF);
    for (int k = 0; k < 16; k++) lane8[k] = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      check_eq("rst_out", {31'b0, out1}, 32'd0);
      check_eq("rst_vld", {31'b0, ov1}, 32'd0);
    end
    rst = 1'b0;
    tick();
    check_eq("post_rst_out", {31'b0, out1}, 32'd1);
    check_eq("post_rst_vld", {31'b0, ov1}, 32'd1);

    // Basic selects on 16'h0F31.
    set_lanes1(16'h0F31);
    sel1 = 4'd2;  tick(); check_eq("sel2",  {31'b0, out1}, 32'd0);
    sel1 = 4'd5;  tick(); check_eq("sel5",  {31'b0, out1}, 32'd1);
    sel1 = 4'd6;  tick(); check_eq("sel6",  {31'b0, out1}, 32'd0);
    sel1 = 4'd0;  tick(); check_eq("sel0",  {31'b0, out1}, 32'd1);
    sel1 = 4'd8;  tick(); check_eq("sel8",  {31'b0, out1}, 32'd1);
    sel1 = 4'd15; tick(); check_eq("sel15", {31'b0, out1}, 32'd0);

    // Back-to-back sweep of every select, pattern then its complement.
    for (int r = 0; r < 2; r++) begin
      pat = (r == 0) ? 16'h0F31 : ~16'h0F31;
      set_lanes1(pat);
      for (int s = 0; s < 16; s++) begin
        sel1 = 4'(s);
        tick();
        check_eq("sweep", {31'b0, out1}, {31'b0, pat[s]});
      end
    end

    // Hold while idle.
    set_lanes1(16'h0F31);
    sel1 = 4'd5; v1 = 1'b1; tick();
    check_eq("hold_pre", {31'b0, out1}, 32'd1);
    v1 = 1'b0; sel1 = 4'd6; set_lanes1(16'h0000);
    tick();
    check_eq("hold_out", {31'b0, out1}, 32'd1);
    check_eq("hold_vld", {31'b0, ov1}, 32'd0);

    // Wide lanes.
    for (int k = 0; k < 16; k++) lane8[k] = 8'hA0 + 8'(k);
    v8 = 1'b1;
    sel8 = 4'd0;  tick(); check_eq("w8_sel0",  {24'b0, out8}, 32'hA0);
    sel8 = 4'd7;  tick(); check_eq("w8_sel7",  {24'b0, out8}, 32'hA7);
    sel8 = 4'd15; tick(); check_eq("w8_sel15", {24'b0, out8}, 32'hAF);

    // Reset coinciding with a valid request discards it.
    set_lanes1(16'h0F31);
    sel1 = 4'd5; v1 = 1'b1; rst = 1'b1;
    tick();
    check_eq("mid_rst_out", {31'b0, out1}, 32'd0);
    check_eq("mid_rst_vld", {31'b0, ov1}, 32'd0);
    rst = 1'b0; v1 = 1'b0; v8 = 1'b0;
    tick();
    check_eq("mid_rst_idle_out", {31'b0, out1}, 32'd0);
    check_eq("mid_rst_idle_vld", {31'b0, ov1}, 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 31) == 0);
      v1   = ($urandom_range(0, 3) != 0);
      v8   = ($urandom_range(0, 3) != 0);
      sel1 = 4'($urandom_range(0, 15));
      sel8 = 4'($urandom_range(0, 15));
      set_lanes1(16'($urandom));
      for (int k = 0; k < 16; k++) lane8[k] = 8'($urandom);
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
